// File: rtl/uart_word_tx.sv
// uart_word_tx: queues BITS-wide words in a small FIFO and sends each one as
// ceil(BITS/DATA_BITS) back-to-back UART frames, LSB chunk first.
// Ports:
//   i_clock    - system clock, rising edge
//   i_reset    - asynchronous active-low reset
//   i_data     - word to transmit
//   i_valid    - i_data valid (accepted when o_ready=1)
//   o_ready    - FIFO not full (combinational from the FIFO count)
//   o_tx       - serial line, idle high
//   o_tx_done  - one-cycle pulse after the last stop bit of a word
//   o_busy     - transmitter active or words still queued
//   o_overflow - sticky: a word was offered while the FIFO was full
module uart_word_tx #(
  parameter int unsigned BITS         = 16,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned FIFO_ADDR    = 2,
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic [BITS-1:0] i_data,
  input  logic            i_valid,
  output logic            o_ready,
  output logic            o_tx,
  output logic            o_tx_done,
  output logic            o_busy,
  output logic            o_overflow
);

  localparam int unsigned NCH    = (BITS + DATA_BITS - 1) / DATA_BITS;
  localparam int unsigned WORD_W = NCH * DATA_BITS;
  localparam int unsigned DEPTH  = 1 << FIFO_ADDR;
  localparam int unsigned CNT_W  = FIFO_ADDR + 1;
  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int unsigned CH_W   = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE
  } state_t;

  logic [BITS-1:0]      r_mem [DEPTH];
  logic [FIFO_ADDR-1:0] r_wr_ptr;
  logic [FIFO_ADDR-1:0] r_rd_ptr;
  logic [CNT_W-1:0]     r_count;

  state_t               r_state;
  logic [BAUD_W-1:0]    r_baud;
  logic [BIT_W-1:0]     r_bit_idx;
  logic                 r_stop_cnt;
  logic [CH_W-1:0]      r_chunk_cnt;
  logic [WORD_W-1:0]    r_word;
  logic                 r_par;
  logic                 r_tx;
  logic                 r_done;
  logic                 r_busy;
  logic                 r_overflow;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_baud_end;
  logic [CNT_W-1:0]     w_count_nxt;

  assign w_full      = (r_count == CNT_W'(DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_push      = i_valid && !w_full;
  assign w_pop       = (r_state == S_IDLE) && !w_empty;
  assign w_baud_end  = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));
  assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

  assign o_ready    = !w_full;
  assign o_tx       = r_tx;
  assign o_tx_done  = r_done;
  assign o_busy     = r_busy;
  assign o_overflow = r_overflow;

  // FIFO storage (data only, no reset needed)
  always_ff @(posedge i_clock) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + FIFO_ADDR'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + FIFO_ADDR'(1);
      r_count <= w_count_nxt;
    end
  end

  // Frame FSM; r_tx carries the bit of the state just left, so the line
  // trails the state by one clock while every bit keeps its full length.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= S_IDLE;
      r_baud      <= '0;
      r_bit_idx   <= '0;
      r_stop_cnt  <= 1'b0;
      r_chunk_cnt <= '0;
      r_word      <= '0;
      r_par       <= 1'b0;
      r_tx        <= 1'b1;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_overflow <= r_overflow | (i_valid & w_full);
      // busy reflects the state/FIFO that this edge produces
      r_busy     <= ((r_state != S_IDLE) && (r_state != S_DONE)) || w_pop ||
                    (w_count_nxt != '0);
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_word      <= WORD_W'(r_mem[r_rd_ptr]);
            r_chunk_cnt <= '0;
            r_baud      <= '0;
            r_state     <= S_START;
          end
        end
        S_START: begin
          r_tx <= 1'b0;
          if (w_baud_end) begin
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_par     <= 1'b0;
            r_state   <= S_DATA;
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end
        S_DATA: begin
          r_tx <= r_word[0];
          if (w_baud_end) begin
            r_baud <= '0;
            r_par  <= r_par ^ r_word[0];
            // shifting the whole word brings the next chunk to the bottom
            r_word <= r_word >> 1;
            if (r_bit_idx == BIT_W'(DATA_BITS - 1)) begin
              r_stop_cnt <= 1'b0;
              r_state    <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + BIT_W'(1);
            end
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end
        S_PARITY: begin
          r_tx <= (PARITY == 2) ? ~r_par : r_par;
          if (w_baud_end) begin
            r_baud     <= '0;
            r_stop_cnt <= 1'b0;
            r_state    <= S_STOP;
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end
        S_STOP: begin
          r_tx <= 1'b1;
          if (w_baud_end) begin
            r_baud <= '0;
            if (r_stop_cnt == 1'(STOP_BITS - 1)) begin
              if (r_chunk_cnt == CH_W'(NCH - 1)) begin
                r_state <= S_DONE;
              end else begin
                r_chunk_cnt <= r_chunk_cnt + CH_W'(1);
                r_state     <= S_START;
              end
            end else begin
              r_stop_cnt <= 1'b1;
            end
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end
        S_DONE: begin
          r_tx    <= 1'b1;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_word_tx.sv
// tb_uart_word_tx: four transmitter configurations on one clock; expected
// line bit streams are built from the framing rules and compared cycle by
// cycle or through a simple mid-bit sampling receiver.
module tb_uart_word_tx;

  localparam int unsigned CPB = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] data;
  logic [3:0]  valid;
  logic [3:0]  ready, tx, done, busy, ovf;

  int n_chk = 0;
  int n_err = 0;
  int done_cnt [4] = '{0, 0, 0, 0};
  bit exp_q [$];

  int c_bits [4] = '{16, 16, 12, 7};
  int c_db   [4] = '{8, 8, 8, 7};
  int c_par  [4] = '{0, 1, 0, 2};
  int c_stop [4] = '{1, 1, 1, 2};

  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) if (done[i] === 1'b1) done_cnt[i] <= done_cnt[i] + 1;
  end

  uart_word_tx #(.BITS(16), .DATA_BITS(8), .FIFO_ADDR(2), .CLKS_PER_BIT(CPB),
                 .PARITY(0), .STOP_BITS(1)) u0 (
    .i_clock(clk), .i_reset(rst_n), .i_data(data), .i_valid(valid[0]),
    .o_ready(ready[0]), .o_tx(tx[0]), .o_tx_done(done[0]), .o_busy(busy[0]),
    .o_overflow(ovf[0]));

  uart_word_tx #(.BITS(16), .DATA_BITS(8), .FIFO_ADDR(2), .CLKS_PER_BIT(CPB),
                 .PARITY(1), .STOP_BITS(1)) u1 (
    .i_clock(clk), .i_reset(rst_n), .i_data(data), .i_valid(valid[1]),
    .o_ready(ready[1]), .o_tx(tx[1]), .o_tx_done(done[1]), .o_busy(busy[1]),
    .o_overflow(ovf[1]));

  uart_word_tx #(.BITS(12), .DATA_BITS(8), .FIFO_ADDR(2), .CLKS_PER_BIT(CPB),
                 .PARITY(0), .STOP_BITS(1)) u2 (
    .i_clock(clk), .i_reset(rst_n), .i_data(data[11:0]), .i_valid(valid[2]),
    .o_ready(ready[2]), .o_tx(tx[2]), .o_tx_done(done[2]), .o_busy(busy[2]),
    .o_overflow(ovf[2]));

  uart_word_tx #(.BITS(7), .DATA_BITS(7), .FIFO_ADDR(2), .CLKS_PER_BIT(CPB),
                 .PARITY(2), .STOP_BITS(2)) u3 (
    .i_clock(clk), .i_reset(rst_n), .i_data(data[6:0]), .i_valid(valid[3]),
    .o_ready(ready[3]), .o_tx(tx[3]), .o_tx_done(done[3]), .o_busy(busy[3]),
    .o_overflow(ovf[3]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference line stream: per chunk start, data LSB first, parity, stops.
  task automatic build_expect(input int sel, input logic [15:0] word);
    int nch;
    int idx;
    bit b;
    bit x;
    exp_q.delete();
    nch = (c_bits[sel] + c_db[sel] - 1) / c_db[sel];
    for (int k = 0; k < nch; k++) begin
      exp_q.push_back(1'b0);
      x = 1'b0;
      for (int i = 0; i < c_db[sel]; i++) begin
        idx = k * c_db[sel] + i;
        b = (idx < c_bits[sel]) ? word[idx] : 1'b0;
        x ^= b;
        exp_q.push_back(b);
      end
      if (c_par[sel] == 1) exp_q.push_back(x);
      if (c_par[sel] == 2) exp_q.push_back(~x);
      for (int s = 0; s < c_stop[sel]; s++) exp_q.push_back(1'b1);
    end
  endtask

  // Push one word from idle and check the line on every clock.
  task automatic exact_word(input int sel, input logic [15:0] word);
    build_expect(sel, word);
    data = word;
    valid[sel] = 1'b1;
    step();                                     // E0
    valid[sel] = 1'b0;
    chk($sformatf("u%0d_idle_e0", sel), tx[sel], 1);
    step();                                     // E1
    chk($sformatf("u%0d_idle_e1", sel), tx[sel], 1);
    for (int j = 0; j < exp_q.size(); j++) begin
      for (int c = 0; c < int'(CPB); c++) begin
        step();
        chk($sformatf("u%0d_bit%0d", sel, j), tx[sel], exp_q[j]);
        chk($sformatf("u%0d_nodone", sel), done[sel], 0);
      end
    end
    step();
    chk($sformatf("u%0d_done", sel), done[sel], 1);
    chk($sformatf("u%0d_done_tx", sel), tx[sel], 1);
    step();
    chk($sformatf("u%0d_done_end", sel), done[sel], 0);
    chk($sformatf("u%0d_busy_end", sel), busy[sel], 0);
  endtask

  // Mid-bit sampling receiver for one word.
  task automatic rx_word(input int sel, input logic [15:0] word);
    int t;
    build_expect(sel, word);
    t = 0;
    while (tx[sel] !== 1'b0 && t < 3000) begin
      step();
      t++;
    end
    if (t >= 3000) begin
      chk($sformatf("u%0d_rx_timeout", sel), 0, 1);
      return;
    end
    repeat (2) step();
    chk($sformatf("u%0d_rx%0h_b0", sel, word), tx[sel], exp_q[0]);
    for (int j = 1; j < exp_q.size(); j++) begin
      repeat (CPB) step();
      chk($sformatf("u%0d_rx%0h_b%0d", sel, word, j), tx[sel], exp_q[j]);
    end
  endtask

  task automatic wait_done(input int base, input int n, input string tag);
    int t;
    t = 0;
    while (done_cnt[0] - base < n && t < 50) begin
      step();
      t++;
    end
    chk(tag, done_cnt[0] - base, n);
  endtask

  initial begin
    logic [15:0] w [8];
    logic [15:0] a;
    int base;
    int len;

    rst_n = 1'b0;
    valid = '0;
    data  = '0;
    repeat (3) step();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_tx%0d", i), tx[i], 1);
      chk($sformatf("rst_ready%0d", i), ready[i], 1);
      chk($sformatf("rst_done%0d", i), done[i], 0);
      chk($sformatf("rst_busy%0d", i), busy[i], 0);
      chk($sformatf("rst_ovf%0d", i), ovf[i], 0);
    end
    rst_n = 1'b1;
    repeat (2) step();

    // directed single words, exact timing
    exact_word(0, 16'hA55A);
    exact_word(1, 16'h0007);
    exact_word(2, 16'h0ABC);
    exact_word(3, 16'h0055);

    // burst of 8 offers from idle: 5 accepted, then overflow
    for (int k = 0; k < 8; k++) w[k] = 16'(k * 16'h1111) ^ 16'($urandom_range(0, 255));
    base = done_cnt[0];
    fork
      begin
        valid[0] = 1'b1;
        for (int k = 0; k < 8; k++) begin
          data = w[k];
          step();
          chk($sformatf("burst_ready%0d", k), ready[0], (k < 4) ? 1 : 0);
          chk($sformatf("burst_ovf%0d", k), ovf[0], (k >= 5) ? 1 : 0);
        end
        valid[0] = 1'b0;
      end
      begin
        for (int k = 0; k < 5; k++) rx_word(0, w[k]);
      end
    join
    wait_done(base, 5, "burst_done_cnt");
    step();
    chk("burst_busy", busy[0], 0);

    // reset during data bit 3 of frame0 with two words queued
    a = 16'($urandom);
    base = done_cnt[0];
    valid[0] = 1'b1;
    data = a;
    step();
    data = 16'($urandom);
    step();
    data = 16'($urandom);
    step();
    valid[0] = 1'b0;
    chk("rst_mid_start", tx[0], 0);
    repeat (17) step();
    chk("rst_mid_bit3", tx[0], {31'd0, a[3]});
    rst_n = 1'b0;
    #1;
    chk("rst_mid_tx", tx[0], 1);
    chk("rst_mid_ready", ready[0], 1);
    chk("rst_mid_busy", busy[0], 0);
    chk("rst_mid_ovf", ovf[0], 0);
    step();
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 100; c++) begin
      step();
      chk("rst_after_tx", tx[0], 1);
    end
    chk("rst_after_done", done_cnt[0] - base, 0);
    chk("rst_after_busy", busy[0], 0);

    // randomized bursts (never beyond capacity) against the scoreboard
    for (int r = 0; r < 4; r++) begin
      len = int'($urandom_range(1, 5));
      for (int k = 0; k < len; k++) w[k] = 16'($urandom);
      base = done_cnt[0];
      fork
        begin
          for (int k = 0; k < len; k++) begin
            repeat ($urandom_range(0, 2)) step();
            chk("rnd_ready", ready[0], 1);
            data = w[k];
            valid[0] = 1'b1;
            step();
            valid[0] = 1'b0;
          end
        end
        begin
          for (int k = 0; k < len; k++) rx_word(0, w[k]);
        end
      join
      wait_done(base, len, "rnd_done_cnt");
      step();
    end
    chk("rnd_ovf", ovf[0], 0);
    for (int i = 1; i < 4; i++) begin
      a = 16'($urandom);
      exact_word(i, a);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
